// File: rtl/id_pair_packer_pkg.sv
// Shared definitions for the ID pair packer: default geometry, lane
// arithmetic, FSM state encoding and the byte-enable helper.
package id_pair_packer_pkg;

    localparam int unsigned VEC_ID_WIDTH_DEF = 8;
    localparam int unsigned PAIR_WIDTH_DEF   = 2 * VEC_ID_WIDTH_DEF;
    localparam int unsigned BUS_WIDTH_DEF    = 128;
    localparam int unsigned CNT_WIDTH_DEF    = 32;

    // Pairs per output word and bytes per pair lane at the default geometry.
    localparam int unsigned PPW = BUS_WIDTH_DEF / PAIR_WIDTH_DEF;
    localparam int unsigned BPL = PAIR_WIDTH_DEF / 8;

    // Widest byte-enable vector the helper below can describe.
    localparam int unsigned KEEP_MAX = 128;

    typedef enum logic [0:0] {
        S_FILL    = 1'b0,
        S_TRAILER = 1'b1
    } state_e;

    // One pair carries two vector IDs.
    function automatic int unsigned pair_width(input int unsigned vec_id_width);
        return 2 * vec_id_width;
    endfunction

    // Byte enables for the lowest `lanes` lanes of `bytes_per_lane` bytes each.
    function automatic logic [KEEP_MAX-1:0] keep_from_lanes(
        input int unsigned lanes,
        input int unsigned bytes_per_lane
    );
        logic [KEEP_MAX-1:0] keep;
        keep = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            keep[i] = (i < lanes * bytes_per_lane);
        end
        return keep;
    endfunction

endpackage

// File: rtl/id_pair_packer_out_reg.sv
// Single-entry AXI-Stream holding register. A load is only issued while
// `free` is high, so a word being drained can be replaced in the same cycle.
// Once valid, data/keep/last stay put until the consumer takes the word.
module id_pack_out_reg #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    output logic              free,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready
);

    logic              valid_q, valid_d;
    logic              last_q,  last_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [KEEP_W-1:0] keep_q,  keep_d;

    // Next-state of the holding register: load wins over drain, else hold.
    always_comb begin
        valid_d = valid_q;
        last_d  = last_q;
        data_d  = data_q;
        keep_d  = keep_q;
        if (load) begin
            valid_d = 1'b1;
            last_d  = load_last;
            data_d  = load_data;
            keep_d  = load_keep;
        end else if (valid_q && m_tready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
        end else begin
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
        end
    end

    assign free     = !valid_q || m_tready;
    assign m_tvalid = valid_q;
    assign m_tlast  = last_q;
    assign m_tdata  = data_q;
    assign m_tkeep  = keep_q;

endmodule

// File: rtl/id_pair_packer.sv
// Packs (ref ID, cmp ID) pairs from the comparator stream into BUS_WIDTH
// words. A run's last pair flushes the partial word with matching tkeep.
// Optional macro ID_PACK_TRAILER_EN appends a pair-count trailer word.
module id_pair_packer
    import id_pair_packer_pkg::*;
#(
    parameter int unsigned BUS_WIDTH    = BUS_WIDTH_DEF,
    parameter int unsigned VEC_ID_WIDTH = VEC_ID_WIDTH_DEF,
    parameter int unsigned PAIR_WIDTH   = pair_width(VEC_ID_WIDTH),
    parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [PAIR_WIDTH-1:0]  s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic [BUS_WIDTH-1:0]   m_tdata,
    output logic [BUS_WIDTH/8-1:0] m_tkeep,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic [CNT_WIDTH-1:0]   pair_count
);

    localparam int unsigned NUM_LANES  = BUS_WIDTH / PAIR_WIDTH;
    localparam int unsigned LANE_BYTES = PAIR_WIDTH / 8;
    localparam int unsigned KEEP_W     = BUS_WIDTH / 8;
    localparam int unsigned LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    state_e                 state_q, state_d;
    logic [LANE_W-1:0]      lane_idx_q, lane_idx_d;
    logic [BUS_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
`ifdef ID_PACK_TRAILER_EN
    logic [CNT_WIDTH-1:0]   cnt_lat_q, cnt_lat_d;
`endif

    logic                   out_free_s;
    logic                   load_s;
    logic [BUS_WIDTH-1:0]   load_data_s;
    logic [KEEP_W-1:0]      load_keep_s;
    logic                   load_last_s;
    logic [BUS_WIDTH-1:0]   merged_s;
    logic [CNT_WIDTH-1:0]   cnt_inc_s;
    logic [KEEP_MAX-1:0]    keep_data_s;
    logic [KEEP_MAX-1:0]    keep_trl_s;
    logic                   s_tready_s;

    // Lane fill, word completion, pair counting and trailer sequencing.
    always_comb begin
        state_d     = state_q;
        lane_idx_d  = lane_idx_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
`ifdef ID_PACK_TRAILER_EN
        cnt_lat_d   = cnt_lat_q;
`endif
        load_s      = 1'b0;
        load_data_s = '0;
        load_keep_s = '0;
        load_last_s = 1'b0;
        cnt_inc_s   = cnt_q + CNT_WIDTH'(1);
        s_tready_s  = (state_q == S_FILL) && out_free_s;

        // Lanes above lane_idx_q are always zero in the accumulator, so the
        // merged word already has its unused lanes cleared.
        merged_s = acc_q;
        merged_s[lane_idx_q * PAIR_WIDTH +: PAIR_WIDTH] = s_tdata;

        keep_data_s = keep_from_lanes(32'(lane_idx_q) + 32'd1, LANE_BYTES);
        keep_trl_s  = keep_from_lanes(32'd1, CNT_WIDTH / 8);

        case (state_q)
            S_FILL: begin
                if (s_tvalid && s_tready_s) begin
                    cnt_d = cnt_inc_s;
                    if ((lane_idx_q == LAST_LANE) || s_tlast) begin
                        load_s      = 1'b1;
                        load_data_s = merged_s;
                        load_keep_s = keep_data_s[KEEP_W-1:0];
                        acc_d       = '0;
                        lane_idx_d  = '0;
                        if (s_tlast) begin
                            cnt_d = '0;
`ifdef ID_PACK_TRAILER_EN
                            cnt_lat_d   = cnt_inc_s;
                            load_last_s = 1'b0;
                            state_d     = S_TRAILER;
`else
                            load_last_s = 1'b1;
`endif
                        end else begin
                            load_last_s = 1'b0;
                        end
                    end else begin
                        acc_d      = merged_s;
                        lane_idx_d = lane_idx_q + LANE_W'(1);
                    end
                end else begin
                    state_d = S_FILL;
                end
            end
`ifdef ID_PACK_TRAILER_EN
            S_TRAILER: begin
                if (out_free_s) begin
                    load_s      = 1'b1;
                    load_data_s[CNT_WIDTH-1:0] = cnt_lat_q;
                    load_keep_s = keep_trl_s[KEEP_W-1:0];
                    load_last_s = 1'b1;
                    state_d     = S_FILL;
                end else begin
                    state_d = S_TRAILER;
                end
            end
`endif
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    // Packer state flops with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_FILL;
            lane_idx_q <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
`ifdef ID_PACK_TRAILER_EN
            cnt_lat_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lane_idx_q <= lane_idx_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
`ifdef ID_PACK_TRAILER_EN
            cnt_lat_q  <= cnt_lat_d;
`endif
        end
    end

    id_pack_out_reg #(
        .DATA_W (BUS_WIDTH),
        .KEEP_W (KEEP_W)
    ) u_out_reg (
        .clk       (clk),
        .rstn      (rstn),
        .load      (load_s),
        .load_data (load_data_s),
        .load_keep (load_keep_s),
        .load_last (load_last_s),
        .free      (out_free_s),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready)
    );

    assign s_tready   = s_tready_s;
    assign pair_count = cnt_q;

endmodule

// File: tb/tb_id_pair_packer.sv
// Self-checking bench for id_pair_packer: directed runs plus randomized runs,
// compared against a queue-based model of the packing rules.
module tb_id_pair_packer;

    localparam int NL = 8;   // pairs per word
    localparam int PW = 16;  // pair width
    localparam int LB = 2;   // bytes per lane

    logic         clk = 1'b0;
    logic         rstn;
    logic [15:0]  s_tdata;
    logic         s_tvalid;
    logic         s_tlast;
    logic         s_tready;
    logic [127:0] m_tdata;
    logic [15:0]  m_tkeep;
    logic         m_tvalid;
    logic         m_tlast;
    logic         m_tready;
    logic [31:0]  pair_count;

    always #5 clk = ~clk;

    id_pair_packer dut (
        .clk        (clk),
        .rstn       (rstn),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tkeep    (m_tkeep),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .pair_count (pair_count)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct { logic [15:0] d; logic l; } pair_t;
    typedef struct { logic [127:0] d; logic [15:0] k; logic l; } word_t;

    pair_t       pend[$];
    word_t       expq[$];
    logic [15:0] run_pairs[$];
    int unsigned model_cnt = 0;

    task automatic add(input logic [15:0] d, input logic l);
        pair_t p;
        p.d = d;
        p.l = l;
        pend.push_back(p);
    endtask

    // Model: group accepted pairs into words of up to NL lanes; returns 1 when a word forms.
    function automatic bit model_accept(input pair_t p);
        word_t w;
        word_t t;
        int    n;
        run_pairs.push_back(p.d);
        model_cnt++;
        if (run_pairs.size() == NL || p.l) begin
            n   = run_pairs.size();
            w.d = '0;
            for (int i = 0; i < n; i++) w.d = w.d | (128'(run_pairs[i]) << (i * PW));
            w.k = 16'((32'd1 << (n * LB)) - 32'd1);
            w.l = p.l;
`ifdef ID_PACK_TRAILER_EN
            w.l = 1'b0;
`endif
            expq.push_back(w);
            run_pairs.delete();
            if (p.l) begin
`ifdef ID_PACK_TRAILER_EN
                t.d = 128'(model_cnt);
                t.k = 16'h000F;
                t.l = 1'b1;
                expq.push_back(t);
`else
                t = w;
`endif
                model_cnt = 0;
            end
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drive pending pairs (gap idle cycles between them), apply a ready pattern, check every cycle.
    task automatic run(input int gap, input int rdy_mode, input int budget);
        int           idle = 0;
        int           c = 0;
        bit           in_hs, out_hs, stalled, formed;
        logic [127:0] hold_d;
        logic [15:0]  hold_k;
        logic         hold_l;
        pair_t        p;
        word_t        w;
        while (c < budget && (pend.size() > 0 || expq.size() > 0 || m_tvalid)) begin
            @(negedge clk);
            if (!s_tvalid) begin
                if (pend.size() > 0 && idle == 0) begin
                    s_tvalid = 1'b1;
                    s_tdata  = pend[0].d;
                    s_tlast  = pend[0].l;
                end else if (idle > 0) begin
                    idle--;
                end
            end
            case (rdy_mode)
                1:       m_tready = !(c >= 6 && c < 11);
                2:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b1;
            endcase
            #1;
            in_hs   = s_tvalid && s_tready;
            out_hs  = m_tvalid && m_tready;
            stalled = m_tvalid && !m_tready;
            hold_d  = m_tdata;
            hold_k  = m_tkeep;
            hold_l  = m_tlast;
            if (stalled) check("s_tready_stall", 128'(s_tready), 128'(0));
            if (out_hs) begin
                if (expq.size() == 0) begin
                    check("extra_word", 128'(m_tvalid), 128'(0));
                end else begin
                    w = expq.pop_front();
                    check("tdata", m_tdata, w.d);
                    check("tkeep", 128'(m_tkeep), 128'(w.k));
                    check("tlast", 128'(m_tlast), 128'(w.l));
                end
            end
            formed = 1'b0;
            if (in_hs) begin
                p      = pend.pop_front();
                formed = model_accept(p);
                idle   = gap;
            end
            @(posedge clk);
            #1;
            if (in_hs) begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
            check("pair_count", 128'(pair_count), 128'(model_cnt));
            if (stalled) begin
                check("hold_valid", 128'(m_tvalid), 128'(1));
                check("hold_data", m_tdata, hold_d);
                check("hold_keep", 128'(m_tkeep), 128'(hold_k));
                check("hold_last", 128'(m_tlast), 128'(hold_l));
            end
            if (formed) check("latency", 128'(m_tvalid), 128'(1));
            c++;
        end
        check("drained", 128'(pend.size() + expq.size()), 128'(0));
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("no_extra", 128'(m_tvalid), 128'(0));
        end
    endtask

    initial begin
        int n;
        rstn     = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 16'h0000;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 128'(m_tvalid), 128'(0));
        check("rst_tdata", m_tdata, 128'(0));
        check("rst_tkeep", 128'(m_tkeep), 128'(0));
        check("rst_tlast", 128'(m_tlast), 128'(0));
        check("rst_count", 128'(pair_count), 128'(0));
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_tready", 128'(s_tready), 128'(1));

        // Full word, tlast on the 8th pair.
        for (int i = 1; i <= 8; i++) add(16'(i), i == 8);
        run(0, 0, 200);

        // Partial word of 3 lanes.
        add(16'hAAAA, 1'b0);
        add(16'hBBBB, 1'b0);
        add(16'hCCCC, 1'b1);
        run(0, 0, 200);

        // 20 pairs with a 5-cycle downstream stall.
        for (int i = 0; i < 20; i++) add(16'($urandom), i == 19);
        run(0, 1, 400);

        // Sparse input: one pair every 4 cycles.
        for (int i = 0; i < 10; i++) add(16'(16'h0100 + i), i == 9);
        run(3, 0, 400);
        check("count_after_run", 128'(pair_count), 128'(0));

        // Reset after 5 pairs, then a fresh 2-pair run.
        for (int i = 0; i < 5; i++) add(16'(16'h5A00 + i), 1'b0);
        run(0, 0, 200);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_count", 128'(pair_count), 128'(0));
        check("mid_rst_tvalid", 128'(m_tvalid), 128'(0));
        run_pairs.delete();
        model_cnt = 0;
        @(negedge clk);
        rstn = 1'b1;
        add(16'h1234, 1'b0);
        add(16'h5678, 1'b1);
        run(0, 0, 200);

        // Nine pairs: full word then a single-lane word.
        for (int i = 1; i <= 9; i++) add(16'(16'h0900 + i), i == 9);
        run(0, 0, 200);

        // Randomized runs.
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) add(16'($urandom), i == n - 1);
            run($urandom_range(0, 2), 2, 1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
